// File: rtl/axi_arb_pkg.sv
// Shared encodings for the AXI write-transaction arbiter: FSM state values and default watchdog limit.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/axi_wr_txn_arbiter_rr_pick.sv
// Round-robin selector: picks the first requester after last_idx, wrapping around.
module rr_pick #(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_idx,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [IDX_W-1:0]       idx
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        sum    = '0;
        cand   = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            sum = {1'b0, last_idx} + SW'(i);
            if (sum >= SW'(NUM_MASTERS))
                sum = sum - SW'(NUM_MASTERS);
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/axi_wr_txn_arbiter.sv
// Grants one whole AXI write transaction (AW, W burst, B) at a time, round-robin.
// Optional watchdog release is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_wr_txn_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           aw_hs,
    input  logic                           w_last_hs,
    input  logic                           b_hs,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx,
    output logic                           grant_valid,
    output logic                           timeout
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("axi_wr_txn_arbiter: parameter out of legal range");
    end

    arb_state_e             state, state_n;
    logic [NUM_MASTERS-1:0] grant_n, pick_onehot;
    logic [IDX_W-1:0]       grant_idx_n, last_idx, last_idx_n, pick_idx;
    logic                   grant_valid_n;
    logic                   w_done, w_done_n;
    logic                   wdog_fire;

    rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_rr_pick (
        .req      (req),
        .last_idx (last_idx),
        .onehot   (pick_onehot),
        .idx      (pick_idx)
    );

`ifdef AXI_ARB_TIMEOUT_EN
    logic [15:0] wdog_cnt;

    assign wdog_fire = (state != IDLE) && (wdog_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change, so it measures time stuck in one phase.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= wdog_fire;
            if (state_n != state || state == IDLE)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + 16'd1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            w_done      <= 1'b0;
            last_idx    <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_idx   <= grant_idx_n;
            grant_valid <= grant_valid_n;
            w_done      <= w_done_n;
            last_idx    <= last_idx_n;
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = grant;
        grant_idx_n   = grant_idx;
        grant_valid_n = grant_valid;
        w_done_n      = w_done;
        last_idx_n    = last_idx;

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_n       = pick_onehot;
                    grant_idx_n   = pick_idx;
                    grant_valid_n = 1'b1;
                    state_n       = ADDR;
                end
            end
            ADDR: begin
                // W may complete before AW; remember it so AW can skip DATA.
                if (aw_hs)
                    state_n = (w_last_hs || w_done) ? RESP : DATA;
                else if (w_last_hs)
                    w_done_n = 1'b1;
            end
            DATA: begin
                if (w_last_hs)
                    state_n = RESP;
            end
            RESP: begin
                if (b_hs) begin
                    state_n       = IDLE;
                    grant_n       = '0;
                    grant_valid_n = 1'b0;
                    w_done_n      = 1'b0;
                    last_idx_n    = grant_idx;
                end
            end
            default: state_n = IDLE;
        endcase

        if (wdog_fire) begin
            state_n       = IDLE;
            grant_n       = '0;
            grant_valid_n = 1'b0;
            w_done_n      = 1'b0;
            last_idx_n    = grant_idx;
        end
    end

endmodule

// File: tb/tb_axi_wr_txn_arbiter.sv
// Directed bench for axi_wr_txn_arbiter: vector table plus a watchdog sequence.
module tb_axi_wr_txn_arbiter;
    import axi_arb_pkg::*;

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = DEFAULT_TIMEOUT_CYCLES;
`endif

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [1:0] req;
    logic       aw_hs, w_last_hs, b_hs;
    logic [1:0] grant;
    logic       grant_idx;
    logic       grant_valid;
    logic       timeout;

    axi_wr_txn_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req         (req),
        .aw_hs       (aw_hs),
        .w_last_hs   (w_last_hs),
        .b_hs        (b_hs),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic       aw, wl, b;
        logic [1:0] g;
        logic       idx;
        logic [1:0] st;
        logic       last;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [1:0] rq, input logic aw, input logic wl, input logic b,
                       input logic [1:0] g, input logic idx, input logic [1:0] st, input logic last);
        vec_t v;
        v = {rst, rq, aw, wl, b, g, idx, st, last};
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        int pulses, first_at;
        logic [1:0] g_before, g_at;

        // rst req aw wl b | grant idx state last
        // single transaction from master 0; stray handshakes ignored
        add(0, 2'b00, 1, 1, 1, 2'b00, 0, IDLE, 1);
        add(0, 2'b01, 0, 0, 0, 2'b01, 0, ADDR, 1);
        add(0, 2'b00, 0, 0, 1, 2'b01, 0, ADDR, 1);
        add(0, 2'b00, 1, 0, 0, 2'b01, 0, DATA, 1);
        add(0, 2'b00, 0, 0, 1, 2'b01, 0, DATA, 1);
        add(0, 2'b00, 0, 1, 0, 2'b01, 0, RESP, 1);
        add(0, 2'b00, 1, 1, 0, 2'b01, 0, RESP, 1);
        add(0, 2'b00, 0, 0, 1, 2'b00, 0, IDLE, 0);
        // both requesting for four transactions: 01,10,01,10 with idle gaps
        add(1, 2'b11, 0, 0, 0, 2'b00, 0, IDLE, 1);
        for (int t = 0; t < 4; t++) begin
            logic       ti;
            logic [1:0] tg;
            ti = t[0];
            tg = ti ? 2'b10 : 2'b01;
            add(0, 2'b11, 0, 0, 0, tg, ti, ADDR, ~ti);
            add(0, 2'b11, 1, 0, 0, tg, ti, DATA, ~ti);
            add(0, 2'b11, 0, 1, 0, tg, ti, RESP, ~ti);
            add(0, 2'b11, 0, 0, 1, 2'b00, ti, IDLE, ti);
        end
        // single requester 1; AW+WLAST together, then WLAST before AW
        add(0, 2'b10, 0, 0, 0, 2'b10, 1, ADDR, 1);
        add(0, 2'b10, 1, 1, 0, 2'b10, 1, RESP, 1);
        add(0, 2'b10, 0, 0, 1, 2'b00, 1, IDLE, 1);
        add(0, 2'b10, 0, 0, 0, 2'b10, 1, ADDR, 1);
        add(0, 2'b00, 0, 1, 0, 2'b10, 1, ADDR, 1);
        add(0, 2'b00, 1, 0, 0, 2'b10, 1, RESP, 1);
        add(0, 2'b00, 0, 0, 1, 2'b00, 1, IDLE, 1);
        // reset while master 1 is in DATA, then req=11 grants master 0
        add(0, 2'b11, 0, 0, 0, 2'b01, 0, ADDR, 1);
        add(0, 2'b11, 1, 0, 0, 2'b01, 0, DATA, 1);
        add(0, 2'b11, 0, 1, 0, 2'b01, 0, RESP, 1);
        add(0, 2'b11, 0, 0, 1, 2'b00, 0, IDLE, 0);
        add(0, 2'b11, 0, 0, 0, 2'b10, 1, ADDR, 0);
        add(0, 2'b11, 1, 0, 0, 2'b10, 1, DATA, 0);
        add(1, 2'b11, 0, 0, 0, 2'b00, 0, IDLE, 1);
        add(0, 2'b11, 0, 0, 0, 2'b01, 0, ADDR, 1);
        add(0, 2'b00, 1, 0, 0, 2'b01, 0, DATA, 1);
        add(0, 2'b00, 0, 1, 0, 2'b01, 0, RESP, 1);
        add(0, 2'b00, 0, 0, 1, 2'b00, 0, IDLE, 0);

        ARESET = 1'b1; req = '0; aw_hs = 0; w_last_hs = 0; b_hs = 0;
        step();
        step();
        check("reset grant", 32'(grant), 0);
        check("reset grant_valid", 32'(grant_valid), 0);
        check("reset grant_idx", 32'(grant_idx), 0);
        check("reset timeout", 32'(timeout), 0);
        check("reset state", 32'(dut.state), 32'(IDLE));
        check("reset last_idx", 32'(dut.last_idx), 1);

        foreach (vecs[i]) begin
            ARESET = vecs[i].rst; req = vecs[i].req;
            aw_hs = vecs[i].aw; w_last_hs = vecs[i].wl; b_hs = vecs[i].b;
            step();
            check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].g));
            check($sformatf("vec%0d grant_valid", i), 32'(grant_valid), 32'(|vecs[i].g));
            check($sformatf("vec%0d grant_idx", i), 32'(grant_idx), 32'(vecs[i].idx));
            check($sformatf("vec%0d timeout", i), 32'(timeout), 0);
            check($sformatf("vec%0d state", i), 32'(dut.state), 32'(vecs[i].st));
            check($sformatf("vec%0d last_idx", i), 32'(dut.last_idx), 32'(vecs[i].last));
        end

        // watchdog: grant master 0 and never complete the address phase
        ARESET = 1'b1; req = '0; aw_hs = 0; w_last_hs = 0; b_hs = 0;
        step();
        ARESET = 1'b0; req = 2'b01;
        step();
        check("wdog grant", 32'(grant), 32'(2'b01));
        req = 2'b00;
        pulses = 0; first_at = 0; g_before = 'x; g_at = 'x;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (timeout === 1'b1) begin
                pulses++;
                if (first_at == 0) first_at = n;
            end
            if (n == 15) g_before = grant;
            if (n == 16) g_at = grant;
        end
`ifdef AXI_ARB_TIMEOUT_EN
        check("wdog pulse count", 32'(pulses), 1);
        check("wdog pulse cycle", 32'(first_at), 16);
        check("wdog grant before", 32'(g_before), 32'(2'b01));
        check("wdog grant cleared", 32'(g_at), 0);
        check("wdog last_idx", 32'(dut.last_idx), 0);
        check("wdog idle", 32'(dut.state), 32'(IDLE));
`else
        check("hold pulse count", 32'(pulses), 0);
        check("hold grant at 16", 32'(g_at), 32'(2'b01));
        check("hold grant at 100", 32'(grant), 32'(2'b01));
        check("hold grant_valid", 32'(grant_valid), 1);
        check("hold state", 32'(dut.state), 32'(ADDR));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
